if_stage: RTL and testbench

Instruction fetch stage for the 32-bit RISC-V pipeline. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel with in-order responses, and buffers returned words. It presents one instruction per cycle to the decode stage, holds its output while decode is stalled, and flushes on a redirect from execute.

---
 rtl/if_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/if_stage.sv | 179 +++++++++++++++++
 tb/tb_if_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared constants, fetch entry type and J-immediate helper for
//            the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL   = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sign-extended J-type immediate of a JAL instruction word
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO of fetch entries with flush. Head is read
//            combinationally; push on a full FIFO is accepted when a pop
//            happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : RV32 instruction fetch stage. Owns the PC, issues word fetches
//            on a valid/ready channel with in-order responses, buffers the
//            returned words and feeds decode one instruction per cycle.
//            Optional: IF_JAL_PREDECODE_EN follows JAL targets at fetch.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int UW = CW + 1;

    logic          started_q;
    logic          pend_q, pend_d;
    logic          pend_drop_q, pend_drop_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   instr_q, pc_q;
    logic          valid_q;

    fetch_entry_t  pb_head, oq_head;
    logic          pb_full, pb_empty, oq_full, oq_empty;
    logic [CW-1:0] pb_count, oq_count;

    logic          w_accept, w_rsp, w_keep, w_pop, w_credit;
    logic [UW-1:0] w_used;
    logic          w_jal;
    logic [31:0]   w_jal_target;
    logic          w_unused;

    assign w_accept = imem_req_valid & imem_req_ready;
    assign w_rsp    = imem_rsp_valid & ~oq_empty;
    assign w_keep   = w_rsp & (drop_q == '0) & ~redirect_valid;
    assign w_pop    = ~redirect_valid & ~stall_in & ~pb_empty;

    // The entry leaving the buffer this cycle frees its slot for a new request,
    // which is what sustains one instruction per cycle at short latency.
    assign w_used   = UW'(pb_count) + UW'(oq_count) - UW'(w_pop);
    assign w_credit = (w_used < UW'(BUF_DEPTH));

    assign imem_req_valid = started_q & (pend_q | w_credit);
    assign imem_req_addr  = pend_q ? pend_addr_q : fetch_pc_q;

`ifdef IF_JAL_PREDECODE_EN
    assign w_jal        = w_keep & (imem_rsp_data[6:0] == OPC_JAL);
    assign w_jal_target = oq_head.pc + j_imm(imem_rsp_data);
`else
    assign w_jal        = 1'b0;
    assign w_jal_target = 32'h0000_0000;
`endif

    assign w_unused = ^{pb_full, oq_full, oq_head.instr, redirect_pc[1:0], w_jal_target[1:0]};

    // Prefetch buffer of returned {pc, instr}
    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_prefetch_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_keep),
        .entry_i ({oq_head.pc, imem_rsp_data}),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .head_o  (pb_head),
        .full_o  (pb_full),
        .empty_o (pb_empty),
        .count_o (pb_count)
    );

    // Addresses of accepted requests awaiting their response
    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_outstanding_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_accept),
        .entry_i ({imem_req_addr, 32'h0000_0000}),
        .pop_i   (w_rsp),
        .flush_i (1'b0),
        .head_o  (oq_head),
        .full_o  (oq_full),
        .empty_o (oq_empty),
        .count_o (oq_count)
    );

    // Next fetch PC, pending-request latch and drop accounting
    always_comb begin
        pend_d      = imem_req_valid & ~imem_req_ready;
        pend_addr_d = imem_req_addr;
        pend_drop_d = pend_drop_q & ~w_accept;
        fetch_pc_d  = fetch_pc_q;
        drop_d      = drop_q;

        // A stale pending request (redirected away) does not advance the PC
        if (w_accept && !pend_drop_q) fetch_pc_d = fetch_pc_q + 32'd4;
        if (w_rsp && drop_q != '0)    drop_d = drop_q - CW'(1);
        if (w_accept && pend_drop_q)  drop_d = drop_d + CW'(1);

        if (redirect_valid) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            drop_d      = oq_count + CW'(w_accept) - CW'(w_rsp);
            pend_drop_d = pend_d;
        end else if (w_jal) begin
            // Everything younger than the JAL itself is on the wrong path
            fetch_pc_d  = {w_jal_target[31:2], 2'b00};
            drop_d      = oq_count - CW'(1) + CW'(w_accept);
            pend_drop_d = pend_d;
        end
    end

    // Fetch-side state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_drop_q <= 1'b0;
            pend_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            drop_q      <= '0;
        end else begin
            started_q   <= 1'b1;
            pend_q      <= pend_d;
            pend_drop_q <= pend_drop_d;
            pend_addr_q <= pend_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_q      <= drop_d;
        end
    end

    // Decode-facing output register: redirect bubbles, stall holds, else pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else if (redirect_valid) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!stall_in) begin
            if (!pb_empty) begin
                instr_q <= pb_head.instr;
                pc_q    <= pb_head.pc;
                valid_q <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign instr_valid = valid_q;

`ifndef SYNTHESIS
    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> !oq_empty);
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: in-order memory model with
//            random latency/ready, scoreboard of expected delivered PCs,
//            table of redirect scenarios and hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;
    import if_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        stall_in = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr_out, pc_out;
    logic        instr_valid;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct {
        logic [31:0] target; int lat; bit rnd; int stall_at; int stall_len; int n;
        logic [31:0] exp_first;
    } vec_t;

    req_t        mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] del_log[$];
    vec_t        vecs[4];

    int vectors = 0, miscompares = 0, cyc = 0, n_del = 0;
    int lat_max = 1;
    bit ready_rand = 0, force_nready = 0, stall_cmd = 0, redir_cmd = 0;
    bit redir_on_rsp = 0, redir_fired = 0, want_first = 0;
    logic [31:0] redir_pc_cmd = 32'h0, seg_start_cmd = 32'h0, first_pc = 32'h0;
    bit prev_pend = 0, prev_stall = 0, prev_redir = 0;
    logic [31:0] prev_addr = 32'h0, prev_pc = 32'h0, prev_instr = 32'h0;
    logic        prev_valid = 1'b0;

    // Memory image: addi-like words tagged with the address, JAL at 0x10 if enabled
    function automatic logic [31:0] prog(input logic [31:0] pc);
`ifdef IF_JAL_PREDECODE_EN
        if (pc == 32'h10) return 32'h0400_006F;
`endif
        return {pc[26:2], 7'h13};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
`ifdef IF_JAL_PREDECODE_EN
        if (pc == 32'h10) return 32'h50;
`endif
        return pc + 32'd4;
    endfunction

    task automatic push_segment(input logic [31:0] start);
        logic [31:0] p = start;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(p);
            p = next_pc(p);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample 1 ns later, before the next posedge
    task automatic step();
        bit rsp_now;
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? prog(mq[0].addr) : 32'hDEAD_BEEF;
        imem_req_ready = force_nready ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        stall_in       = stall_cmd;
        redirect_valid = redir_cmd | (redir_on_rsp & rsp_now);
        redirect_pc    = redir_pc_cmd;
        if (redirect_valid) begin
            exp_q.delete();
            push_segment(seg_start_cmd);
            want_first   = 1;
            redir_fired  = 1;
            redir_on_rsp = 0;
        end
        #1;
        if (rst_n) begin
            if (prev_pend) begin
                chk("req_valid_held", 32'(imem_req_valid), 32'd1);
                chk("req_addr_held", imem_req_addr, prev_addr);
            end
            if (prev_redir) begin
                chk("redir_bubble_valid", 32'(instr_valid), 32'd0);
                chk("redir_bubble_nop", instr_out, NOP_INSTR);
            end else if (prev_stall) begin
                chk("stall_hold_pc", pc_out, prev_pc);
                chk("stall_hold_instr", instr_out, prev_instr);
                chk("stall_hold_valid", 32'(instr_valid), 32'(prev_valid));
            end
            if (instr_valid && !stall_in && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard: got pc %h expected none", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_out", pc_out, e);
                    chk("instr_out", instr_out, prog(e));
                end
                if (want_first) begin
                    first_pc   = pc_out;
                    want_first = 0;
                end
                if (del_log.size() < 8) del_log.push_back(pc_out);
                n_del++;
            end
        end
        if (rsp_now) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(1, lat_max))});
            if (acc_log.size() < 3) acc_log.push_back(imem_req_addr);
        end
        if (rst_n) chk("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        prev_pend  = imem_req_valid & ~imem_req_ready;
        prev_addr  = imem_req_addr;
        prev_stall = stall_in;
        prev_redir = redirect_valid;
        prev_pc    = pc_out;
        prev_instr = instr_out;
        prev_valid = instr_valid;
        redir_cmd  = 0;
    endtask

    initial begin
        int k;
        int base;
        vecs[0] = '{target: 32'h0000_0100, lat: 1, rnd: 0, stall_at: 4, stall_len: 5, n: 12, exp_first: 32'h0000_0100};
        vecs[1] = '{target: 32'h0000_0203, lat: 3, rnd: 1, stall_at: 0, stall_len: 0, n: 20, exp_first: 32'h0000_0200};
        vecs[2] = '{target: 32'hFFFF_FFF8, lat: 2, rnd: 1, stall_at: 2, stall_len: 5, n: 10, exp_first: 32'hFFFF_FFF8};
        vecs[3] = '{target: 32'h0000_0040, lat: 3, rnd: 0, stall_at: 6, stall_len: 3, n: 12, exp_first: 32'h0000_0040};

        push_segment(32'h0);
        want_first = 1;
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr", instr_out, NOP_INSTR);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("pre_rsp_valid", 32'(instr_valid), 32'd0);
        chk("pre_rsp_instr", instr_out, NOP_INSTR);

        k = 0;
        while (n_del == 0 && k < 50) begin step(); k++; end
        chk("first_delivery_seen", 32'(n_del >= 1), 32'd1);
        chk("first_pc_after_reset", first_pc, 32'h0);
        repeat (4) step();
        chk("one_per_cycle", 32'(n_del), 32'd5);
        chk("req_addr0", acc_log[0], 32'h0);
        chk("req_addr1", acc_log[1], 32'h4);
        chk("req_addr2", acc_log[2], 32'h8);
        k = 0;
        while (n_del < 6 && k < 50) begin step(); k++; end
        chk("del4_pc", del_log[4], 32'h10);
        chk("del5_pc", del_log[5], next_pc(32'h10));

        lat_max = 2;
        repeat (6) step();

        for (int i = 0; i < 4; i++) begin
            redir_cmd     = 1;
            redir_pc_cmd  = vecs[i].target;
            seg_start_cmd = vecs[i].exp_first;
            step();
            lat_max    = vecs[i].lat;
            ready_rand = vecs[i].rnd;
            base = n_del;
            k = 0;
            while ((n_del - base) < vecs[i].n && k < 400) begin
                if (vecs[i].stall_len > 0 && (n_del - base) == vecs[i].stall_at && k >= 0) begin
                    stall_cmd = 1;
                    repeat (vecs[i].stall_len) step();
                    stall_cmd = 0;
                    k += vecs[i].stall_len;
                    vecs[i].stall_len = 0;
                end
                step();
                k++;
            end
            chk($sformatf("vec%0d_done", i), 32'(n_del - base >= vecs[i].n), 32'd1);
            chk($sformatf("vec%0d_first_pc", i), first_pc, vecs[i].exp_first);
        end

        // Redirect coinciding with a response while a request is held pending
        lat_max    = 3;
        ready_rand = 0;
        repeat (10) step();
        force_nready  = 1;
        redir_pc_cmd  = 32'h0000_0302;
        seg_start_cmd = 32'h0000_0300;
        redir_fired   = 0;
        step();
        redir_on_rsp = 1;
        k = 0;
        while (!redir_fired && k < 20) begin step(); k++; end
        chk("rsp_redirect_fired", 32'(redir_fired), 32'd1);
        repeat (2) step();
        force_nready = 0;
        base = n_del;
        k = 0;
        while ((n_del - base) < 8 && k < 200) begin step(); k++; end
        chk("rsp_redirect_done", 32'(n_del - base >= 8), 32'd1);
        chk("rsp_redirect_first_pc", first_pc, 32'h0000_0300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
